serial_subtractor: RTL and testbench

- Bit-serial, handshaked subtractor; computes iData0 - iData1 on unsigned BITWIDTH-bit operands, one bit per enabled cycle, LSB first.
- Inverse-direction companion to the combinational adder. Shares its operand and result widths (BITWIDTH in, BITWIDTH+1 out) so the two are interchangeable in datapaths.
- Trades N cycles of latency for a single full-subtractor cell plus shift registers.

---
 rtl/serial_subtractor_if.sv | 23 ++
 rtl/serial_subtractor.sv | 103 ++++++++++
 tb/tb_serial_subtractor.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// The design receives operands on the slave side and presents the result there.
interface serial_subtractor_if #(
    parameter int BITWIDTH = 8
);
    logic                iValid;
    logic                oReady;
    logic [BITWIDTH-1:0] iData0;
    logic [BITWIDTH-1:0] iData1;
    logic                oValid;
    logic                iReady;
    logic [BITWIDTH:0]   oData;

    modport slave (
        input  iValid, iData0, iData1, iReady,
        output oReady, oValid, oData
    );

    modport master (
        output iValid, iData0, iData1, iReady,
        input  oReady, oValid, oData
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial iData0 - iData1, LSB first, one full-subtractor cell per enabled cycle.
// The result is BITWIDTH+1 bits wide; the top bit is the final borrow, which is the sign.
module serial_subtractor #(
    parameter int BITWIDTH = 8
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iEn,
    input  logic                 iClr,
    serial_subtractor_if.slave   bus
);
    localparam int CW = $clog2(BITWIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                borrow_q, borrow_d;
    logic [BITWIDTH-1:0] a_q, a_d;
    logic [BITWIDTH-1:0] b_q, b_d;
    logic [BITWIDTH-1:0] res_q, res_d;
    logic [BITWIDTH:0]   data_q, data_d;

    logic                diff;
    logic                borrow_nxt;
    logic [BITWIDTH:0]   res_shift;

    assign diff       = a_q[0] ^ b_q[0] ^ borrow_q;
    assign borrow_nxt = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & borrow_q);
    // New bit enters from the MSB side so bit 0 ends at the LSB after BITWIDTH shifts.
    assign res_shift  = {diff, res_q};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        data_d   = data_q;
        if (iClr) begin
            state_d  = IDLE;
            cnt_d    = '0;
            borrow_d = 1'b0;
            a_d      = '0;
            b_d      = '0;
            res_d    = '0;
            data_d   = '0;
        end else if (iEn) begin
            case (state_q)
                IDLE: begin
                    if (bus.iValid) begin
                        a_d      = bus.iData0;
                        b_d      = bus.iData1;
                        borrow_d = 1'b0;
                        cnt_d    = '0;
                        state_d  = RUN;
                    end
                end
                RUN: begin
                    res_d    = res_shift[BITWIDTH:1];
                    a_d      = a_q >> 1;
                    b_d      = b_q >> 1;
                    borrow_d = borrow_nxt;
                    cnt_d    = cnt_q + CW'(1);
                    if (cnt_q == CW'(BITWIDTH - 1)) begin
                        data_d  = {borrow_nxt, res_shift[BITWIDTH:1]};
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (bus.iReady) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            data_q   <= data_d;
        end
    end

    // Gated by iRst so ready falls the moment reset asserts, not at the next edge.
    assign bus.oReady = (state_q == IDLE) & iEn & ~iRst;
    assign bus.oValid = (state_q == DONE);
    assign bus.oData  = data_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at BITWIDTH=8: latency, signed results,
// stalls, backpressure, synchronous/asynchronous abort and back-to-back traffic.
module tb_serial_subtractor;
    localparam int N = 8;

    logic iClk;
    logic iRst;
    logic iEn;
    logic iClr;
    int   errors;
    int   checks;
    int   cyc;

    serial_subtractor_if #(.BITWIDTH(N)) bus ();

    serial_subtractor #(.BITWIDTH(N)) dut (
        .iClk (iClk),
        .iRst (iRst),
        .iEn  (iEn),
        .iClr (iClr),
        .bus  (bus.slave)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    initial cyc = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    // Waits for oValid with a cycle bound; returns cycles elapsed.
    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.oValid && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        iRst = 1'b1; iEn = 1'b1; iClr = 1'b0;
        bus.iValid = 1'b0; bus.iReady = 1'b0; bus.iData0 = '0; bus.iData1 = '0;
        repeat (2) tick();
        checks++;
        if (bus.oReady !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b want=0", bus.oReady); end
        checks++;
        if (bus.oValid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", bus.oValid); end
        checks++;
        if (bus.oData !== 9'h000) begin errors++; $display("FAIL reset_data got=%h want=000", bus.oData); end
        iRst = 1'b0;
        #1;
        checks++;
        if (bus.oReady !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b want=1", bus.oReady); end
        tick();
    endtask

    // One full transaction with iEn held high; checks latency, result and return to IDLE.
    task automatic run_one(input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [N:0] exp, input string name);
        int n;
        bus.iData0 = a; bus.iData1 = b; bus.iValid = 1'b1;
        n = 0;
        while (!bus.oReady && n < 40) begin tick(); n++; end
        tick();
        bus.iValid = 1'b0;
        bus.iData0 = ~a; bus.iData1 = ~b;
        checks++;
        if (bus.oReady !== 1'b0) begin errors++; $display("FAIL %s_ready_drop got=%b want=0", name, bus.oReady); end
        wait_valid(n);
        checks++;
        if (n !== N) begin errors++; $display("FAIL %s_latency got=%0d want=%0d", name, n, N); end
        checks++;
        if (bus.oData !== exp) begin errors++; $display("FAIL %s_data got=%h want=%h", name, bus.oData, exp); end
        bus.iReady = 1'b1;
        tick();
        bus.iReady = 1'b0;
        checks++;
        if (bus.oValid !== 1'b0 || bus.oReady !== 1'b1)
        begin errors++; $display("FAIL %s_idle got=v%b r%b want=v0 r1", name, bus.oValid, bus.oReady); end
        checks++;
        if (bus.oData !== exp) begin errors++; $display("FAIL %s_hold got=%h want=%h", name, bus.oData, exp); end
    endtask

    task automatic test_arith();
        run_one(8'd20, 8'd10, 9'h00A, "sub_20_10");
        run_one(8'd10, 8'd20, 9'h1F6, "sub_10_20");
        run_one(8'd0, 8'd255, 9'h101, "sub_0_255");
        run_one(8'd255, 8'd0, 9'h0FF, "sub_255_0");
        run_one(8'd77, 8'd77, 9'h000, "sub_77_77");
    endtask

    task automatic test_stall();
        int n;
        iEn = 1'b0;
        bus.iValid = 1'b1; bus.iData0 = 8'd100; bus.iData1 = 8'd1;
        #1;
        checks++;
        if (bus.oReady !== 1'b0) begin errors++; $display("FAIL stall_idle_ready got=%b want=0", bus.oReady); end
        tick();
        checks++;
        if (bus.oReady !== 1'b0) begin errors++; $display("FAIL stall_no_accept got=%b want=0", bus.oReady); end
        iEn = 1'b1;
        tick();
        bus.iValid = 1'b0;
        n = 0;
        while (!bus.oValid && n < 40) begin
            if (n == 2) iEn = 1'b0;
            if (n == 5) iEn = 1'b1;
            tick();
            n++;
        end
        checks++;
        if (n !== N + 3) begin errors++; $display("FAIL stall_latency got=%0d want=%0d", n, N + 3); end
        checks++;
        if (bus.oData !== 9'h063) begin errors++; $display("FAIL stall_data got=%h want=063", bus.oData); end
        bus.iReady = 1'b1;
        tick();
        bus.iReady = 1'b0;
    endtask

    task automatic test_backpressure();
        int n;
        bus.iData0 = 8'd5; bus.iData1 = 8'd3; bus.iValid = 1'b1;
        tick();
        bus.iValid = 1'b0;
        wait_valid(n);
        bus.iValid = 1'b1; bus.iData0 = 8'd9; bus.iData1 = 8'd1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (bus.oValid !== 1'b1 || bus.oData !== 9'h002 || bus.oReady !== 1'b0)
            begin errors++; $display("FAIL bp_hold_%0d got=v%b d%h r%b want=v1 d002 r0", i, bus.oValid, bus.oData, bus.oReady); end
        end
        bus.iReady = 1'b1;
        tick();
        bus.iReady = 1'b0;
        bus.iValid = 1'b0;
        checks++;
        if (bus.oValid !== 1'b0 || bus.oReady !== 1'b1)
        begin errors++; $display("FAIL bp_release got=v%b r%b want=v0 r1", bus.oValid, bus.oReady); end
        run_one(8'd9, 8'd1, 9'h008, "bp_next");
    endtask

    task automatic test_abort();
        bus.iData0 = 8'd50; bus.iData1 = 8'd7; bus.iValid = 1'b1;
        tick();
        bus.iValid = 1'b0;
        repeat (4) tick();
        iClr = 1'b1;
        tick();
        iClr = 1'b0;
        checks++;
        if (bus.oValid !== 1'b0 || bus.oData !== 9'h000 || bus.oReady !== 1'b1)
        begin errors++; $display("FAIL clr_state got=v%b d%h r%b want=v0 d000 r1", bus.oValid, bus.oData, bus.oReady); end
        repeat (10) tick();
        checks++;
        if (bus.oValid !== 1'b0) begin errors++; $display("FAIL clr_no_result got=%b want=0", bus.oValid); end
        run_one(8'd3, 8'd1, 9'h002, "clr_fresh");

        bus.iData0 = 8'd200; bus.iData1 = 8'd100; bus.iValid = 1'b1;
        tick();
        bus.iValid = 1'b0;
        repeat (3) tick();
        #2 iRst = 1'b1;
        #1;
        checks++;
        if (bus.oValid !== 1'b0 || bus.oData !== 9'h000 || bus.oReady !== 1'b0)
        begin errors++; $display("FAIL arst_immediate got=v%b d%h r%b want=v0 d000 r0", bus.oValid, bus.oData, bus.oReady); end
        iRst = 1'b0;
        tick();
        checks++;
        if (bus.oReady !== 1'b1 || bus.oValid !== 1'b0)
        begin errors++; $display("FAIL arst_idle got=r%b v%b want=r1 v0", bus.oReady, bus.oValid); end
        run_one(8'd3, 8'd1, 9'h002, "arst_fresh");
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] va [3];
        logic [N-1:0] vb [3];
        logic [N:0]   ve [3];
        int           acc [3];
        int           n;
        va[0] = 8'd20; vb[0] = 8'd10;  ve[0] = 9'h00A;
        va[1] = 8'd10; vb[1] = 8'd20;  ve[1] = 9'h1F6;
        va[2] = 8'd0;  vb[2] = 8'd255; ve[2] = 9'h101;
        bus.iReady = 1'b1;
        bus.iValid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.iData0 = va[k]; bus.iData1 = vb[k];
            n = 0;
            while (!bus.oReady && n < 40) begin tick(); n++; end
            tick();
            acc[k] = cyc;
            bus.iData0 = 8'hAA; bus.iData1 = 8'h55;
            wait_valid(n);
            checks++;
            if (bus.oValid !== 1'b1 || bus.oData !== ve[k])
            begin errors++; $display("FAIL b2b_data_%0d got=v%b d%h want=v1 d%h", k, bus.oValid, bus.oData, ve[k]); end
            if (k > 0) begin
                checks++;
                if (acc[k] - acc[k-1] !== N + 2)
                begin errors++; $display("FAIL b2b_spacing_%0d got=%0d want=%0d", k, acc[k] - acc[k-1], N + 2); end
            end
        end
        bus.iValid = 1'b0;
        tick();
        bus.iReady = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_arith();
        test_stall();
        test_backpressure();
        test_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
